gen_lane_accum: RTL and testbench
=================================

GEN_LANE_ACCUM -- requirements
Module: gen_lane_accum

Interface
REQ-001 SHALL have parameter LENGTH, default 2, giving the number of lanes (legal range 1..8).
REQ-002 SHALL have parameter WIDTH, default 8, giving the data width of a, x and the accumulators.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream sample on a is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: the sample value.
REQ-008 SHALL have port out_valid, output, 1 bit: the round total on x is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream block takes x.
REQ-010 SHALL have port x, output, WIDTH bits: the grand total of all lane accumulators.
REQ-011 SHALL have port lane, output, 3 bits: the current lane pointer.
REQ-012 SHALL have port rounds, output, 8 bits: the count of completed drain handshakes.

Function
REQ-013 SHALL implement the FSM states ACCUM and DRAIN.
REQ-014 SHALL drive in_ready=1 only in ACCUM and out_valid=1 only in DRAIN.
REQ-015 SHALL treat in_valid&&in_ready as an accept: acc[lane] <= acc[lane]+a, modulo 2^WIDTH.
REQ-016 SHALL advance lane by 1 on each accept, wrapping from LENGTH-1 to 0.
REQ-017 SHALL move from ACCUM to DRAIN on the accept at lane LENGTH-1, so out_valid rises the cycle after that accept.
REQ-018 SHALL drive x, in DRAIN, as the sum of all acc[i] modulo 2^WIDTH, including the final accept.
REQ-019 SHALL drive x=0 outside DRAIN.
REQ-020 SHALL hold x, lane and the accumulators stable in DRAIN while out_ready=0.
REQ-021 SHALL, on out_valid&&out_ready, return to ACCUM in the next cycle and increment rounds, which wraps 255->0.
REQ-022 SHALL keep accumulators as running totals across rounds; only rst clears them.
REQ-023 SHALL, when LENGTH=1, enter DRAIN on every accept.
REQ-024 SHALL never have an accept and a drain handshake in the same cycle, because in_ready and out_valid are mutually exclusive.
REQ-025 SHALL declare each lane accumulator inside a named generate for-loop block gen_loop[i] as reg acc, so that each lane is a distinct public scope.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set state=ACCUM, lane=0, rounds=0, all acc=0, out_valid=0, in_ready=1 and x=0.
REQ-027 SHALL let rst override any in-flight accept or drain handshake in the same cycle.
REQ-028 SHALL, after rst deasserts, accept a sample on the first cycle.

Configuration
REQ-029 SHALL, when GEN_LANE_ACCUM_SAT_EN is defined, saturate each lane add and the x sum at 2^WIDTH-1.
REQ-030 SHALL, when GEN_LANE_ACCUM_SAT_EN is undefined, wrap each lane add and the x sum modulo 2^WIDTH.

Verification
REQ-031 SHALL cover basic accumulation (LENGTH=2): rst, then accept a=3 and a=4 -> out_valid the cycle after the second accept, x=7, lane=0, in_ready=0.
REQ-032 SHALL cover backpressure: hold out_ready=0 for 5 cycles in DRAIN -> x stays 7 and in_ready stays 0; then out_ready=1 -> rounds=1, ACCUM on the next cycle.
REQ-033 SHALL cover running totals: a second round with a=1 and a=1 -> x=9, rounds=2 after the handshake.
REQ-034 SHALL cover overflow: from reset, accept a=200 and a=100 -> x=44 without the macro, x=255 with GEN_LANE_ACCUM_SAT_EN.
REQ-035 SHALL cover reset mid-round: rst after one accept of a=9 -> lane=0, then a=1 and a=2 -> x=3, rounds=0.
REQ-036 SHALL cover LENGTH=1 and counter wrap: a=5 -> out_valid, x=5; after 256 handshakes -> rounds=0.

Source files
------------

// File: rtl/gen_lane_accum.sv
`default_nettype none
// ============================================================================
//  Module   : gen_lane_accum
//  Brief    : Round-robin per-lane accumulators; after each full round the
//             grand total is offered on x with a valid/ready handshake.
//             Define GEN_LANE_ACCUM_SAT_EN to saturate adds instead of wrap.
//  Revision : 1.0
// ============================================================================
module gen_lane_accum #(
  parameter int LENGTH = 2,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [2:0]       lane,
  output logic [7:0]       rounds
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [2:0]       c_LAST = 3'(LENGTH - 1);
  localparam logic [WIDTH-1:0] c_MAX  = '1;
`ifdef GEN_LANE_ACCUM_SAT_EN
  localparam int c_SUM_W = WIDTH + 3;
`else
  localparam int c_SUM_W = WIDTH;
`endif

  state_t             r_state;
  logic [2:0]         r_lane;
  logic [7:0]         r_rounds;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               w_accept;
  logic [WIDTH-1:0]   w_acc [LENGTH];
  logic [c_SUM_W-1:0] w_sum;
  logic [WIDTH-1:0]   w_total;

  assign w_accept = in_valid && r_in_ready;

  for (genvar i = 0; i < LENGTH; i++) begin : gen_loop
    reg [WIDTH-1:0] acc;
`ifdef GEN_LANE_ACCUM_SAT_EN
    logic [WIDTH:0] w_add;
    assign w_add = {1'b0, acc} + {1'b0, a};
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        acc <= '0;
      end else if (w_accept && (r_lane == 3'(i))) begin
`ifdef GEN_LANE_ACCUM_SAT_EN
        acc <= w_add[WIDTH] ? c_MAX : w_add[WIDTH-1:0];
`else
        acc <= acc + a;
`endif
      end
    end
    assign w_acc[i] = acc;
  end

  // Accumulators are frozen in DRAIN, so a combinational total is stable there.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LENGTH; k++) begin
      w_sum = w_sum + c_SUM_W'(w_acc[k]);
    end
  end

`ifdef GEN_LANE_ACCUM_SAT_EN
  assign w_total = (w_sum > c_SUM_W'(c_MAX)) ? c_MAX : w_sum[WIDTH-1:0];
`else
  assign w_total = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_lane      <= '0;
      r_rounds    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (r_lane == c_LAST) begin
              r_lane      <= '0;
              r_state     <= DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_lane <= r_lane + 3'd1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            r_state     <= ACCUM;
            r_rounds    <= r_rounds + 8'd1;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign x         = r_out_valid ? w_total : '0;
  assign lane      = r_lane;
  assign rounds    = r_rounds;

endmodule
`default_nettype wire

// File: tb/tb_gen_lane_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gen_lane_accum
//  Brief    : Directed and randomized checks of gen_lane_accum (LENGTH=2 and
//             LENGTH=1 instances) against a behavioural round model.
//  Revision : 1.0
// ============================================================================
module tb_gen_lane_accum;

  localparam int MAXV = 255;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, x, rounds;
  logic [2:0] lane;
  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0] a1, x1, rounds1;
  logic [2:0] lane1;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model of the LENGTH=2 instance
  int m_acc [2];
  int m_lane, m_rounds;
  bit m_drain;

  gen_lane_accum #(.LENGTH(2), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .lane(lane), .rounds(rounds)
  );

  gen_lane_accum #(.LENGTH(1), .WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1),
    .out_valid(out_valid1), .out_ready(out_ready1), .x(x1), .lane(lane1), .rounds(rounds1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clip(input int v);
`ifdef GEN_LANE_ACCUM_SAT_EN
    return (v > MAXV) ? MAXV : v;
`else
    return v % (MAXV + 1);
`endif
  endfunction

  function automatic int model_x();
    if (!m_drain) return 0;
    return clip(m_acc[0] + m_acc[1]);
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic accept(input logic [7:0] v);
    in_valid = 1'b1; a = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (x !== 8'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", x); end
    n_tests++; if (lane !== 3'd0) begin n_fail++; $display("FAIL reset_lane got %0d want 0", lane); end
    n_tests++; if (rounds !== 8'd0) begin n_fail++; $display("FAIL reset_rounds got %0d want 0", rounds); end
  endtask

  task automatic test_basic();
    accept(8'd3);
    n_tests++; if (lane !== 3'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_mid lane=%0d ov=%b want 1/0", lane, out_valid); end
    accept(8'd4);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    n_tests++; if (x !== 8'd7) begin n_fail++; $display("FAIL basic_x got %0d want 7", x); end
    n_tests++; if (lane !== 3'd0) begin n_fail++; $display("FAIL basic_lane got %0d want 0", lane); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready got %b want 0", in_ready); end
    n_tests++; if (dut.gen_loop[0].acc !== 8'd3) begin n_fail++; $display("FAIL basic_acc0 got %0d want 3", dut.gen_loop[0].acc); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; a = 8'hFF; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (x !== 8'd7 || in_ready !== 1'b0 || lane !== 3'd0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d x=%0d ir=%b lane=%0d ov=%b want 7/0/0/1", i, x, in_ready, lane, out_valid);
      end
    end
    in_valid = 1'b0;
    handshake();
    n_tests++; if (rounds !== 8'd1) begin n_fail++; $display("FAIL bp_rounds got %0d want 1", rounds); end
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || x !== 8'd0) begin
      n_fail++; $display("FAIL bp_accum ir=%b ov=%b x=%0d want 1/0/0", in_ready, out_valid, x);
    end
  endtask

  task automatic test_running();
    accept(8'd1);
    accept(8'd1);
    n_tests++; if (x !== 8'd9 || out_valid !== 1'b1) begin n_fail++; $display("FAIL running_x got %0d ov=%b want 9/1", x, out_valid); end
    handshake();
    n_tests++; if (rounds !== 8'd2) begin n_fail++; $display("FAIL running_rounds got %0d want 2", rounds); end
  endtask

  task automatic test_overflow();
    int exp;
    do_reset();
    accept(8'd200);
    accept(8'd100);
`ifdef GEN_LANE_ACCUM_SAT_EN
    exp = 255;
`else
    exp = 44;
`endif
    n_tests++; if (x !== 8'(exp)) begin n_fail++; $display("FAIL overflow_x got %0d want %0d", x, exp); end
    handshake();
  endtask

  task automatic test_reset_mid();
    do_reset();
    accept(8'd9);
    rst = 1'b1; in_valid = 1'b1; a = 8'd50;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    n_tests++; if (lane !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_lane got %0d ir=%b want 0/1", lane, in_ready); end
    accept(8'd1);
    accept(8'd2);
    n_tests++; if (x !== 8'd3 || rounds !== 8'd0) begin n_fail++; $display("FAIL rstmid_x got %0d rounds=%0d want 3/0", x, rounds); end
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    n_tests++; if (rounds !== 8'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_drain rounds=%0d ov=%b want 0/0", rounds, out_valid); end
  endtask

  task automatic test_random();
    logic [23:0] got, exp;
    do_reset();
    m_acc[0] = 0; m_acc[1] = 0; m_lane = 0; m_rounds = 0; m_drain = 0;
    for (int c = 0; c < 600; c++) begin
      exp = {!m_drain, m_drain, 8'(model_x()), 3'(m_lane), 8'(m_rounds), 3'd0};
      got = {in_ready, out_valid, x, lane, rounds, 3'd0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random cyc %0d ir/ov/x/lane/rounds got %b/%b/%0d/%0d/%0d want %b/%b/%0d/%0d/%0d",
                 c, in_ready, out_valid, x, lane, rounds, !m_drain, m_drain, model_x(), m_lane, m_rounds);
      end
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      if (rst) begin
        m_acc[0] = 0; m_acc[1] = 0; m_lane = 0; m_rounds = 0; m_drain = 0;
      end else if (!m_drain && in_valid) begin
        m_acc[m_lane] = clip(m_acc[m_lane] + int'(a));
        if (m_lane == 1) begin m_lane = 0; m_drain = 1; end
        else m_lane = m_lane + 1;
      end else if (m_drain && out_ready) begin
        m_drain = 0;
        m_rounds = (m_rounds + 1) % 256;
      end
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_len1_wrap();
    do_reset();
    in_valid1 = 1'b1; a1 = 8'd5;
    @(negedge clk);
    in_valid1 = 1'b0;
    n_tests++; if (out_valid1 !== 1'b1 || x1 !== 8'd5 || lane1 !== 3'd0 || in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL len1_first ov=%b x=%0d lane=%0d ir=%b want 1/5/0/0", out_valid1, x1, lane1, in_ready1);
    end
    for (int i = 1; i <= 256; i++) begin
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      if (i == 255) begin
        n_tests++; if (rounds1 !== 8'd255) begin n_fail++; $display("FAIL len1_r255 got %0d want 255", rounds1); end
      end
      if (i < 256) begin
        in_valid1 = 1'b1; a1 = 8'd0;
        @(negedge clk);
        in_valid1 = 1'b0;
      end
    end
    n_tests++; if (rounds1 !== 8'd0) begin n_fail++; $display("FAIL len1_wrap rounds got %0d want 0", rounds1); end
    n_tests++; if (out_valid1 !== 1'b0 || x1 !== 8'd0 || in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL len1_end ov=%b x=%0d ir=%b want 0/0/1", out_valid1, x1, in_ready1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_running();
    test_overflow();
    test_reset_mid();
    test_random();
    test_len1_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
